decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, 64, operand/PC/immediate width; only 64 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  fetch presents an instruction.
REQ-005 in_ready  out  1  decode accepts the instruction this cycle.
REQ-006 in_instr  in  32  LEGv8 instruction word.
REQ-007 in_pc  in  XLEN  PC of in_instr.
REQ-008 rf_a, rf_b  out  5 each  register bank read addresses (combinational from in_instr).
REQ-009 rf_dataA, rf_dataB  in  XLEN each  register bank read data (combinational).
REQ-010 wb_w, wb_c, wb_data  in  1/5/XLEN  write-back strobe, address, data (the same values drive the bank write port).
REQ-011 out_valid / out_ready  out / in  1 each  handshake toward execute.
REQ-012 out_pc, out_opA, out_opB, out_imm  out  XLEN each  registered PC, operands, immediate.
REQ-013 out_rd  out  5;  out_regwrite  out  1;  out_class  out  3;  out_alu_fn  out  2.

Function
REQ-014 Decode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> class 1 (ALU_R); ADDI [31:22]=1001000100 -> class 2; LDUR 11111000010 -> class 3; STUR 11111000000 -> class 4; CBZ [31:24]=10110100 -> class 5; B [31:26]=000101 -> class 6; anything else -> class 0 (NOP).
REQ-015 alu_fn: ADD/ADDI/LDUR/STUR 0, SUB 1, AND 2, ORR 3; 0 for CBZ, B, NOP.
REQ-016 rf_a = instr[9:5]; rf_b = instr[20:16] for class 1, instr[4:0] for classes 4 and 5, else 0.
REQ-017 Immediate: ADDI zero-extends [21:10]; LDUR/STUR sign-extend [20:12]; CBZ sign-extends [23:5] shifted left 2; B sign-extends [25:0] shifted left 2; otherwise 0.
REQ-018 out_regwrite = 1 for classes 1, 2, 3 with rd = instr[4:0] != 31; else 0; out_rd = instr[4:0] always (0 for NOP).
REQ-019 Register 31 reads as zero on both operands, regardless of bank contents or bypass.
REQ-020 Bypass: if wb_w and wb_c equals a nonzero-31 source address in the same cycle, that operand takes wb_data instead of the bank data.
REQ-021 Unused operands (opB for classes 2, 3, 6, 0; opA for 5, 6, 0) are forced to 0.
REQ-022 Busy scoreboard: 32-bit vector; the LDUR destination bit is set when the LDUR is accepted (in_valid and in_ready), unless rd = 31.
REQ-023 A busy bit is cleared when wb_w and wb_c match that bit; a simultaneous set and clear of the same bit leaves it set.
REQ-024 Hazard: instruction sources (per REQ-016, excluding 31) whose busy bit is set after REQ-023 same-cycle clearing (wb clears bypass).
REQ-025 in_ready = !hazard and (!out_valid or out_ready).
REQ-026 On accept, all out_* registers load the decoded values and out_valid = 1; otherwise, if out_ready, out_valid = 0.
REQ-027 While out_valid and !out_ready, all out_* outputs hold stable.
REQ-028 Latency: an instruction accepted in cycle N appears on out_* in cycle N+1; throughput is 1 per cycle without hazard or backpressure.
REQ-029 NOP-class instructions are accepted and forwarded with out_regwrite = 0 and never set busy bits.

Reset
REQ-030 While rst is high: out_valid = 0, all out_* data = 0, busy vector = 0, in_ready = 0.
REQ-031 Reset mid-operation discards any held output and all pending load tracking; the first accept occurs in the cycle after rst falls.

Verification
REQ-032 ADD X3,X1,X2 with bank X1=1, X2=2, out_ready=1 -> next cycle: out_opA=1, out_opB=2, out_class=1, out_alu_fn=0, out_rd=3, out_regwrite=1.
REQ-033 ADDI X5,X4,#4095 with wb_w=1, wb_c=4, wb_data=0xAA in the same cycle -> out_opA=0xAA, out_imm=0xFFF.
REQ-034 LDUR X6,[X4,#-8] accepted, then ADD X7,X6,X6 -> in_ready=0 until wb_w=1, wb_c=6, then accepted that cycle with opA=opB=wb_data; LDUR out_imm=0xFFFFFFFFFFFFFFF8.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged, in_ready=0; on release, one transfer per cycle resumes.
REQ-036 CBZ X31 with offset -1 -> out_opB=0, out_imm=0xFFFFFFFFFFFFFFFC; B with offset 1 -> out_imm=4; both with out_regwrite=0.
REQ-037 rst asserted with out_valid=1 and busy[6] set -> next cycle out_valid=0, busy cleared, and ADD X7,X6,X6 is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/decode_stage.sv
// LEGv8 decode stage: decodes, reads/bypasses operands and tracks in-flight loads; result registered one cycle after accept.
// Backpressure: holds the output register while out_ready is low and stalls fetch (in_ready=0) on a load-use hazard or a full output.
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_a,
  output logic [4:0]      rf_b,
  input  logic [XLEN-1:0] rf_dataA,
  input  logic [XLEN-1:0] rf_dataB,
  input  logic            wb_w,
  input  logic [4:0]      wb_c,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_opA,
  output logic [XLEN-1:0] out_opB,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic [2:0]      out_class,
  output logic [1:0]      out_alu_fn
);

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALUR  = 3'd1,
    CLS_ADDI  = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4,
    CLS_CBZ   = 3'd5,
    CLS_B     = 3'd6
  } instrClassT;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            regwrite;
    logic [2:0]      cls;
    logic [1:0]      aluFn;
  } decT;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  instrClassT cls;
  logic [1:0] aluFn;
  logic [XLEN-1:0] imm;
  logic [4:0] rd;
  logic useA, useB, hazard, accept;
  logic [31:0] busy, busyEff, clrMask, setMask;
  decT dec, outReg;

  always_comb begin
    cls   = CLS_NOP;
    aluFn = 2'd0;
    if (in_instr[31:21] == OP_ADD) begin
      cls = CLS_ALUR;
    end else if (in_instr[31:21] == OP_SUB) begin
      cls   = CLS_ALUR;
      aluFn = 2'd1;
    end else if (in_instr[31:21] == OP_AND) begin
      cls   = CLS_ALUR;
      aluFn = 2'd2;
    end else if (in_instr[31:21] == OP_ORR) begin
      cls   = CLS_ALUR;
      aluFn = 2'd3;
    end else if (in_instr[31:22] == 10'b1001000100) begin
      cls = CLS_ADDI;
    end else if (in_instr[31:21] == OP_LDUR) begin
      cls = CLS_LOAD;
    end else if (in_instr[31:21] == OP_STUR) begin
      cls = CLS_STORE;
    end else if (in_instr[31:24] == 8'b10110100) begin
      cls = CLS_CBZ;
    end else if (in_instr[31:26] == 6'b000101) begin
      cls = CLS_B;
    end
  end

  always_comb begin
    case (cls)
      CLS_ADDI:            imm = {{(XLEN-12){1'b0}}, in_instr[21:10]};
      CLS_LOAD, CLS_STORE: imm = {{(XLEN-9){in_instr[20]}}, in_instr[20:12]};
      CLS_CBZ:             imm = {{(XLEN-21){in_instr[23]}}, in_instr[23:5], 2'b00};
      CLS_B:               imm = {{(XLEN-28){in_instr[25]}}, in_instr[25:0], 2'b00};
      default:             imm = '0;
    endcase
  end

  // Only operands the instruction actually consumes are read, bypassed or hazard-checked.
  assign useA = (cls == CLS_ALUR) || (cls == CLS_ADDI) || (cls == CLS_LOAD) || (cls == CLS_STORE);
  assign useB = (cls == CLS_ALUR) || (cls == CLS_STORE) || (cls == CLS_CBZ);
  assign rd   = (cls == CLS_NOP) ? 5'd0 : in_instr[4:0];
  assign rf_a = in_instr[9:5];
  assign rf_b = !useB ? 5'd0 : ((cls == CLS_ALUR) ? in_instr[20:16] : in_instr[4:0]);

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.imm      = imm;
    dec.rd       = rd;
    dec.cls      = cls;
    dec.aluFn    = aluFn;
    dec.regwrite = ((cls == CLS_ALUR) || (cls == CLS_ADDI) || (cls == CLS_LOAD)) && (rd != 5'd31);
    if (useA && rf_a != 5'd31)
      dec.opA = (wb_w && wb_c == rf_a) ? wb_data : rf_dataA;
    if (useB && rf_b != 5'd31)
      dec.opB = (wb_w && wb_c == rf_b) ? wb_data : rf_dataB;
  end

  // A write-back in the same cycle both clears the busy bit and supplies the bypass value.
  assign clrMask = wb_w ? (32'd1 << wb_c) : 32'd0;
  assign busyEff = busy & ~clrMask;
  assign hazard  = (useA && rf_a != 5'd31 && busyEff[rf_a]) ||
                   (useB && rf_b != 5'd31 && busyEff[rf_b]);
  assign in_ready = !rst && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign setMask  = (accept && cls == CLS_LOAD && rd != 5'd31) ? (32'd1 << rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      outReg    <= '0;
      out_valid <= 1'b0;
    end else begin
      busy <= busyEff | setMask;
      if (accept) begin
        outReg    <= dec;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_pc       = outReg.pc;
  assign out_opA      = outReg.opA;
  assign out_opB      = outReg.opB;
  assign out_imm      = outReg.imm;
  assign out_rd       = outReg.rd;
  assign out_regwrite = outReg.regwrite;
  assign out_class    = outReg.cls;
  assign out_alu_fn   = outReg.aluFn;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/operands plus hazard, bypass, backpressure and reset sequences.
module tb_decode_stage;

  localparam int XLEN = 64;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, wb_w, out_valid, out_ready, out_regwrite;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc, rf_dataA, rf_dataB, wb_data, out_pc, out_opA, out_opB, out_imm;
  logic [4:0] rf_a, rf_b, wb_c, out_rd;
  logic [2:0] out_class;
  logic [1:0] out_alu_fn;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_a(rf_a), .rf_b(rf_b),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB), .wb_w(wb_w), .wb_c(wb_c),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opA(out_opA), .out_opB(out_opB), .out_imm(out_imm),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_class(out_class),
    .out_alu_fn(out_alu_fn)
  );

  // Register bank model: Xi = i after reset, X31 holds junk that must never be seen.
  logic [63:0] bank [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= (i == 31) ? 64'hDEAD_BEEF : 64'(i);
    end else if (wb_w) begin
      bank[wb_c] <= wb_data;
    end
  end
  assign rf_dataA = bank[rf_a];
  assign rf_dataB = bank[rf_b];

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  cls;
    logic [1:0]  fn;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] opA;
    logic [63:0] opB;
    logic [63:0] imm;
  } vecT;

  vecT vecs [13];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rType(input logic [10:0] opc, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {opc, rm, 6'b000000, rn, rd};
  endfunction
  function automatic logic [31:0] dType(input logic [10:0] opc, input logic [8:0] off, input logic [4:0] rn, input logic [4:0] rt);
    return {opc, off, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] iAddi(input logic [11:0] imm12, input logic [4:0] rn, input logic [4:0] rd);
    return {10'b1001000100, imm12, rn, rd};
  endfunction
  function automatic logic [31:0] iCbz(input logic [18:0] off, input logic [4:0] rt);
    return {8'b10110100, off, rt};
  endfunction
  function automatic logic [31:0] iB(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chkOut(input string tag, input vecT v);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".pc"}, out_pc, v.pc);
    chk({tag, ".class"}, 64'(out_class), 64'(v.cls));
    chk({tag, ".alu_fn"}, 64'(out_alu_fn), 64'(v.fn));
    chk({tag, ".rd"}, 64'(out_rd), 64'(v.rd));
    chk({tag, ".regwrite"}, 64'(out_regwrite), 64'(v.rw));
    chk({tag, ".opA"}, out_opA, v.opA);
    chk({tag, ".opB"}, out_opB, v.opB);
    chk({tag, ".imm"}, out_imm, v.imm);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    wb_w = 1'b0; wb_c = 5'd0; wb_data = 64'd0;
    drive(1'b0, 32'd0, 64'd0);

    vecs[0]  = '{rType(OP_ADD, 5'd2, 5'd1, 5'd3),    64'h1000, 3'd1, 2'd0, 5'd3,  1'b1, 64'd1, 64'd2, 64'd0};
    vecs[1]  = '{rType(OP_SUB, 5'd6, 5'd5, 5'd4),    64'h1004, 3'd1, 2'd1, 5'd4,  1'b1, 64'd5, 64'd6, 64'd0};
    vecs[2]  = '{rType(OP_AND, 5'd8, 5'd7, 5'd31),   64'h1008, 3'd1, 2'd2, 5'd31, 1'b0, 64'd7, 64'd8, 64'd0};
    vecs[3]  = '{rType(OP_ORR, 5'd9, 5'd31, 5'd10),  64'h100C, 3'd1, 2'd3, 5'd10, 1'b1, 64'd0, 64'd9, 64'd0};
    vecs[4]  = '{iAddi(12'hFFF, 5'd4, 5'd5),          64'h1010, 3'd2, 2'd0, 5'd5,  1'b1, 64'd4, 64'd0, 64'hFFF};
    vecs[5]  = '{dType(OP_STUR, 9'h1FF, 5'd13, 5'd12), 64'h1014, 3'd4, 2'd0, 5'd12, 1'b0, 64'd13, 64'd12, ONES};
    vecs[6]  = '{iCbz(19'h7FFFF, 5'd31),              64'h1018, 3'd5, 2'd0, 5'd31, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[7]  = '{iCbz(19'd2, 5'd8),                   64'h101C, 3'd5, 2'd0, 5'd8,  1'b0, 64'd0, 64'd8, 64'd8};
    vecs[8]  = '{iB(26'd1),                           64'h1020, 3'd6, 2'd0, 5'd1,  1'b0, 64'd0, 64'd0, 64'd4};
    vecs[9]  = '{iB(26'h3FFFFFF),                     64'h1024, 3'd6, 2'd0, 5'd31, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[10] = '{32'h0000_0000,                       64'h1028, 3'd0, 2'd0, 5'd0,  1'b0, 64'd0, 64'd0, 64'd0};
    vecs[11] = '{32'hB500_0000,                       64'h102C, 3'd0, 2'd0, 5'd0,  1'b0, 64'd0, 64'd0, 64'd0};
    vecs[12] = '{dType(OP_LDUR, 9'h1F8, 5'd4, 5'd9),  64'h1030, 3'd3, 2'd0, 5'd9,  1'b1, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8};

    // Reset: an offered instruction is refused and outputs stay cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b1, vecs[0].instr, vecs[0].pc);
    #1 chk("rst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_pc", out_pc, 64'd0);
    chk("rst.out_opA", out_opA, 64'd0);
    chk("rst.out_class", 64'(out_class), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back vectors, one accepted per cycle.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      #1 chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      chkOut($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Same-cycle write-back bypass on operand A.
    drive(1'b1, iAddi(12'hFFF, 5'd4, 5'd5), 64'h2000);
    wb_w = 1'b1; wb_c = 5'd4; wb_data = 64'hAA;
    #1 chk("byp.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("byp.opA", out_opA, 64'hAA);
    chk("byp.imm", out_imm, 64'hFFF);
    @(negedge clk);
    wb_w = 1'b0;

    // Load-use hazard released by write-back of the load destination.
    drive(1'b1, dType(OP_LDUR, 9'h1F8, 5'd4, 5'd6), 64'h2004);
    #1 chk("ld.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("ld.imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ld.opA", out_opA, 64'hAA);
    chk("ld.regwrite", 64'(out_regwrite), 64'd1);
    @(negedge clk);
    drive(1'b1, rType(OP_ADD, 5'd6, 5'd6, 5'd7), 64'h2008);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("haz%0d.in_ready", k), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("haz%0d.out_valid", k), 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    wb_w = 1'b1; wb_c = 5'd6; wb_data = 64'h1234_5678_9ABC_DEF0;
    #1 chk("haz.release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("haz.out_valid", 64'(out_valid), 64'd1);
    chk("haz.opA", out_opA, 64'h1234_5678_9ABC_DEF0);
    chk("haz.opB", out_opB, 64'h1234_5678_9ABC_DEF0);
    chk("haz.rd", 64'(out_rd), 64'd7);
    @(negedge clk);
    wb_w = 1'b0;

    // Backpressure: output held for three cycles, then one transfer per cycle.
    drive(1'b1, rType(OP_ADD, 5'd2, 5'd1, 5'd3), 64'h3000);
    #1 chk("bp.first.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, rType(OP_SUB, 5'd8, 5'd5, 5'd4), 64'h3004);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d.out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d.out_pc", k), out_pc, 64'h3000);
      chk($sformatf("bp%0d.out_opA", k), out_opA, 64'd1);
      chk($sformatf("bp%0d.out_opB", k), out_opB, 64'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp.release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp.sub.pc", out_pc, 64'h3004);
    chk("bp.sub.opA", out_opA, 64'd5);
    chk("bp.sub.opB", out_opB, 64'd8);
    chk("bp.sub.alu_fn", 64'(out_alu_fn), 64'd1);
    @(negedge clk);
    drive(1'b1, rType(OP_ORR, 5'd2, 5'd1, 5'd10), 64'h3008);
    #1 chk("bp.next.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp.orr.pc", out_pc, 64'h3008);
    chk("bp.orr.alu_fn", 64'(out_alu_fn), 64'd3);
    @(negedge clk);

    // Reset with a held output and a pending load.
    drive(1'b1, dType(OP_LDUR, 9'h1F8, 5'd4, 5'd6), 64'h4000);
    #1 chk("rl.ld.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, rType(OP_ADD, 5'd6, 5'd6, 5'd7), 64'h4004);
    #1 chk("rl.busy6.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 32'h0000_0000, 64'h4008);
    #1 chk("rl.nop.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    drive(1'b1, rType(OP_ADD, 5'd6, 5'd6, 5'd7), 64'h4004);
    #1 chk("rl.rst.held_valid", 64'(out_valid), 64'd1);
    chk("rl.rst.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rl.rst.out_valid", 64'(out_valid), 64'd0);
    chk("rl.rst.out_pc", out_pc, 64'd0);
    chk("rl.rst.out_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rl.post.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("rl.post.out_valid", 64'(out_valid), 64'd1);
    chk("rl.post.opA", out_opA, 64'd6);
    chk("rl.post.opB", out_opB, 64'd6);
    chk("rl.post.rd", 64'(out_rd), 64'd7);
    @(negedge clk);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
